// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory, decode-handshake and status signals of the fetch unit.
interface instr_fetch_unit_if;
    logic        i_start;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_instr;
    logic [15:0] o_imm16;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_br_taken;
    logic [31:0] i_br_offset;
    logic        i_halt;
    logic [31:0] o_pc;
    logic [15:0] o_instr_count;
    modport master (
        input  i_start, i_mem_ack, i_mem_rdata, i_instr_ready, i_br_taken, i_br_offset, i_halt,
        output o_mem_req, o_mem_addr, o_instr, o_imm16, o_instr_valid, o_pc, o_instr_count
    );
    modport slave (
        output i_start, i_mem_ack, i_mem_rdata, i_instr_ready, i_br_taken, i_br_offset, i_halt,
        input  o_mem_req, o_mem_addr, o_instr, o_imm16, o_instr_valid, o_pc, o_instr_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction at a time, holds it for decode, then
// advances pc sequentially or by a taken branch until a halt is accepted.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [15:0] r_count;
    logic        w_accept;
    logic [31:0] w_step;

    assign w_accept = (r_state == S_HOLD) && bus.i_instr_ready;
    // br_offset counts words, so it is scaled to bytes before adding
    assign w_step   = bus.i_br_taken ? 32'd4 + (bus.i_br_offset << 2) : 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_count <= 16'd0;
        end else if (r_state == S_IDLE && bus.i_start) begin
            r_state <= S_FETCH;
        end else if (r_state == S_FETCH && bus.i_mem_ack) begin
            r_state <= S_HOLD;
            r_instr <= bus.i_mem_rdata;
        end else if (w_accept) begin
            r_count <= r_count + 16'd1;
            r_state <= bus.i_halt ? S_HALT : S_FETCH;
            r_pc    <= bus.i_halt ? r_pc : r_pc + w_step;
        end
    end

    // outputs decode straight from registers so reset forces them without a clock edge
    assign bus.o_mem_req     = r_state == S_FETCH;
    assign bus.o_mem_addr    = r_pc;
    assign bus.o_instr       = r_instr;
    assign bus.o_imm16       = r_instr[15:0];
    assign bus.o_instr_valid = r_state == S_HOLD;
    assign bus.o_pc          = r_pc;
    assign bus.o_instr_count = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, reset/wrap sequences, then random
// stimulus against a flag-based reference model of the fetch rules.
module tb_instr_fetch_unit;
    logic clk = 0;
    logic rst_n = 0;
    int n_tests = 0;
    int n_fail = 0;

    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        start, ack;
        logic [31:0] rdata;
        logic        ready, br;
        logic [31:0] off;
        logic        halt;
        logic        e_req, e_valid;
        logic [31:0] e_pc, e_instr;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tbl [23];

    logic        m_fetching, m_holding, m_halted;
    logic [31:0] m_pc, m_instr;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, ak, input logic [31:0] rd, input logic rdy, b,
                         input logic [31:0] of, input logic h);
        bus.i_start = st; bus.i_mem_ack = ak; bus.i_mem_rdata = rd;
        bus.i_instr_ready = rdy; bus.i_br_taken = b; bus.i_br_offset = of; bus.i_halt = h;
    endtask

    task automatic chk_state(input string tag, input logic req, valid,
                             input logic [31:0] pc, instr, input logic [15:0] cnt);
        chk({tag, ".req"}, {31'd0, bus.o_mem_req}, {31'd0, req});
        chk({tag, ".valid"}, {31'd0, bus.o_instr_valid}, {31'd0, valid});
        chk({tag, ".pc"}, bus.o_pc, pc);
        chk({tag, ".instr"}, bus.o_instr, instr);
        chk({tag, ".imm16"}, {16'd0, bus.o_imm16}, {16'd0, instr[15:0]});
        chk({tag, ".cnt"}, {16'd0, bus.o_instr_count}, {16'd0, cnt});
        if (req) chk({tag, ".addr"}, bus.o_mem_addr, pc);
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 0;
        #1;
        chk_state(tag, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0);
        chk({tag, ".rst_addr"}, bus.o_mem_addr, 32'd0);
        rst_n = 1;
        m_fetching = 0; m_holding = 0; m_halted = 0;
        m_pc = 32'd0; m_instr = 32'd0; m_cnt = 16'd0;
    endtask

    task automatic model_step();
        if (m_halted) begin
        end else if (m_holding) begin
            if (bus.i_instr_ready) begin
                m_cnt = m_cnt + 16'd1;
                m_holding = 0;
                if (bus.i_halt) m_halted = 1;
                else begin
                    m_pc = m_pc + 32'd4 + (bus.i_br_taken ? bus.i_br_offset * 32'd4 : 32'd0);
                    m_fetching = 1;
                end
            end
        end else if (m_fetching) begin
            if (bus.i_mem_ack) begin
                m_instr = bus.i_mem_rdata;
                m_fetching = 0;
                m_holding = 1;
            end
        end else if (bus.i_start) m_fetching = 1;
    endtask

    initial begin
        tbl[0]  = '{1,1,32'h0,0,0,32'h0,0,                 0,0,32'h0,32'h0,16'd0};
        tbl[1]  = '{0,0,32'h0,1,1,32'h8,1,                 1,0,32'h0,32'h0,16'd0};
        tbl[2]  = '{0,0,32'h0,0,0,32'h0,0,                 1,0,32'h0,32'h0,16'd0};
        tbl[3]  = '{0,1,32'h2000FFDB,0,0,32'h0,0,          1,0,32'h0,32'h0,16'd0};
        tbl[4]  = '{0,0,32'h0,1,0,32'h0,0,                 0,1,32'h0,32'h2000FFDB,16'd0};
        tbl[5]  = '{0,1,32'h11111111,0,0,32'h0,0,          1,0,32'h4,32'h2000FFDB,16'd1};
        tbl[6]  = '{0,0,32'h0,1,0,32'h0,0,                 0,1,32'h4,32'h11111111,16'd1};
        tbl[7]  = '{0,1,32'h22222222,0,0,32'h0,0,          1,0,32'h8,32'h11111111,16'd2};
        tbl[8]  = '{0,0,32'h0,1,0,32'h0,0,                 0,1,32'h8,32'h22222222,16'd2};
        tbl[9]  = '{0,1,32'h33333333,0,0,32'h0,0,          1,0,32'hC,32'h22222222,16'd3};
        tbl[10] = '{0,0,32'h0,1,1,32'h3C,0,                0,1,32'hC,32'h33333333,16'd3};
        tbl[11] = '{0,1,32'h44444444,0,0,32'h0,0,          1,0,32'h100,32'h33333333,16'd4};
        tbl[12] = '{0,0,32'h0,1,1,32'hFFFFFFDB,0,          0,1,32'h100,32'h44444444,16'd4};
        tbl[13] = '{0,1,32'h5555ABCD,0,0,32'h0,0,          1,0,32'h70,32'h44444444,16'd5};
        for (int i = 14; i < 19; i++)
            tbl[i] = '{1,1,32'h0,0,1,32'h12345,1,          0,1,32'h70,32'h5555ABCD,16'd5};
        tbl[19] = '{0,0,32'h0,1,1,32'h3C,1,                0,1,32'h70,32'h5555ABCD,16'd5};
        tbl[20] = '{1,0,32'h0,0,0,32'h0,0,                 0,0,32'h70,32'h5555ABCD,16'd6};
        tbl[21] = '{1,1,32'h9,1,0,32'h0,0,                 0,0,32'h70,32'h5555ABCD,16'd6};
        tbl[22] = '{0,0,32'h0,0,0,32'h0,0,                 0,0,32'h70,32'h5555ABCD,16'd6};

        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_pulse("rst0");
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            chk_state($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_valid,
                      tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_cnt);
            drive(tbl[i].start, tbl[i].ack, tbl[i].rdata, tbl[i].ready,
                  tbl[i].br, tbl[i].off, tbl[i].halt);
        end

        // reset during FETCH, then a late ack must not produce an instruction
        @(negedge clk);
        reset_pulse("rst_halt");
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midfetch.req_before", {31'd0, bus.o_mem_req}, 32'd1);
        reset_pulse("rst_fetch");
        drive(0, 1, 32'hDEADBEEF, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_state("late_ack", 1'b0, 1'b0, 32'd0, 32'd0, 16'd0);
        end
        // reset during HOLD drops the held instruction
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'hCAFE1234, 0, 0, 0, 0);
        @(negedge clk);
        chk_state("hold_pre", 1'b0, 1'b1, 32'd0, 32'hCAFE1234, 16'd0);
        reset_pulse("rst_hold");

        // pc wraps from 0xFFFFFFFC to 0
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'hA, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h3FFFFFFE, 0);
        @(negedge clk);
        chk_state("wrap_hi", 1'b1, 1'b0, 32'hFFFFFFFC, 32'hA, 16'd1);
        drive(0, 1, 32'hB, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk_state("wrap_lo", 1'b1, 1'b0, 32'h0, 32'hB, 16'd2);

        @(negedge clk);
        reset_pulse("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            chk_state("rand", m_fetching, m_holding, m_pc, m_instr, m_cnt);
            if ($urandom_range(0, 59) == 0) reset_pulse("rand_rst");
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32),
                  $urandom_range(0, 39) == 0);
            model_step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the byte address loaded into pc on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port start  input  1  SHALL start fetching when sampled high in IDLE.
REQ-005 Port mem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 Port mem_addr  output  32  SHALL be the instruction-memory byte address.
REQ-007 Port mem_ack  input  1  SHALL be the memory acknowledge; mem_rdata is valid in the same cycle.
REQ-008 Port mem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-009 Port instr  output  32  SHALL be the registered fetched instruction.
REQ-010 Port imm16  output  16  SHALL equal instr[15:0]; it is the operand fed to the 16-to-32 sign-extension stage.
REQ-011 Port instr_valid  output  1  SHALL be high when instr holds an unconsumed instruction.
REQ-012 Port instr_ready  input  1  SHALL be high when decode accepts instr.
REQ-013 Port br_taken  input  1  SHALL be the decode decision that the held instruction is a taken branch.
REQ-014 Port br_offset  input  32  SHALL be the sign-extended word offset of the held instruction.
REQ-015 Port halt  input  1  SHALL be the decode flag that the held instruction is a halt.
REQ-016 Port pc  output  32  SHALL be the address of the held or in-flight instruction.
REQ-017 Port instr_count  output  16  SHALL count accepted instructions.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, FETCH, HOLD, HALT.
REQ-019 In IDLE: mem_req=0, instr_valid=0; start=1 -> FETCH next cycle; start=0 -> stay.
REQ-020 In FETCH: mem_req=1 and mem_addr=pc, both held stable until the cycle mem_ack=1.
REQ-021 In FETCH with mem_ack=1: instr<=mem_rdata; next state HOLD; instr_valid=1 from the next cycle (one-cycle capture latency).
REQ-022 In HOLD: mem_req=0; instr, imm16 and pc SHALL stay stable until instr_valid & instr_ready.
REQ-023 On accept (HOLD & instr_ready): instr_count<=instr_count+1 (wraps 16'hFFFF->0); instr_valid drops the next cycle.
REQ-024 On accept with halt=1: next state HALT, pc unchanged; halt SHALL take priority over br_taken.
REQ-025 On accept with halt=0, br_taken=1: pc<=pc+4+(br_offset<<2), modulo 2^32; next state FETCH.
REQ-026 On accept with halt=0, br_taken=0: pc<=pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0); next state FETCH.
REQ-027 br_taken, br_offset and halt SHALL be ignored outside an accept cycle.
REQ-028 mem_ack outside FETCH SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-029 HALT SHALL hold until reset: mem_req=0, instr_valid=0, pc frozen.
REQ-030 pc[1:0] SHALL remain 2'b00 whenever RESET_PC[1:0]=2'b00.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, mem_addr=RESET_PC, instr_count=0.
REQ-032 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the request or instruction; a later mem_ack SHALL have no effect.
REQ-033 After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 Reset, start=1, mem_ack after 2 wait cycles with mem_rdata=32'h2000FFDB -> mem_addr=0 throughout FETCH; next cycle instr_valid=1, imm16=16'hFFDB, pc=0.
REQ-035 Three accepts with br_taken=0, immediate acks -> mem_addr sequence 0, 4, 8; instr_count=3.
REQ-036 pc=32'h100, accept with br_taken=1, br_offset=32'hFFFFFFDB (-37) -> next pc=32'h70, mem_addr=32'h70.
REQ-037 instr_ready held low 5 cycles in HOLD -> instr, imm16 and pc stable, mem_req=0 throughout; accept on cycle 6.
REQ-038 Accept with halt=1 and br_taken=1 -> state HALT, pc unchanged, mem_req stays 0; further start pulses have no effect.
REQ-039 rst_n pulsed low during FETCH -> mem_req=0 without waiting for a clock edge, pc=RESET_PC; a subsequent mem_ack with no start -> instr_valid stays 0.
